// File: rtl/game_pkg.sv
// Shared game constants: scene encodings, counter widths, session start
// values and the hp_tracker FSM state codes.
package game_pkg;

    // Scene encodings produced by the scene FSM
    localparam logic [1:0] SC_OPEN = 2'b00;
    localparam logic [1:0] SC_GAME = 2'b01;
    localparam logic [1:0] SC_WIN  = 2'b10;
    localparam logic [1:0] SC_LOSE = 2'b11;

    // Counter widths
    localparam int HP_W   = 10;
    localparam int LIFE_W = 2;
    localparam int INV_W  = 6;

    // Session start values and invulnerability length (~2 s of clk_22)
    localparam logic [HP_W-1:0]   BOSS_HP_INIT = 10'd500;
    localparam logic [LIFE_W-1:0] LIFE_INIT    = 2'd3;
    localparam logic [INV_W-1:0]  INV_TICKS    = 6'd48;

    // hp_tracker FSM state codes
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_INVULN = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef logic [HP_W-1:0]   hp_t;
    typedef logic [LIFE_W-1:0] life_t;

endpackage

// File: rtl/inv_timer.sv
// Loadable down-counter that times post-hit player invulnerability.
// 'load' captures 'ticks', 'start' raises 'busy'; busy stays high for exactly
// 'ticks' cycles. 'expire' flags the last busy cycle so the owner can leave
// its invulnerable state on the same edge that busy drops.
module inv_timer #(
    parameter int W = 6
) (
    input  logic         clk_22,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         start,
    input  logic [W-1:0] ticks,
    output logic         busy,
    output logic         expire,
    output logic [W-1:0] count
);

    // Count down while busy; clear/reset win over load and start
    always_ff @(posedge clk_22) begin
        if (!rst_n || clear) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            if (load) begin
                count <= ticks;
            end else if (busy && count != W'(1)) begin
                count <= count - W'(1);
            end else if (busy) begin
                count <= '0;
            end

            if (start) begin
                busy <= 1'b1;
            end else if (busy && count == W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Last invulnerable cycle: counter reads 1
    assign expire = busy && (count == W'(1));

endmodule

// File: rtl/hp_tracker.sv
// Boss hit-point and player life counters for one play session.
// Inputs boss_hit / player_hit are single-cycle pulses with no handshake:
// a pulse is consumed on the edge it is sampled, there is no valid/ready
// back-pressure, and a pulse arriving while hits are ignored is dropped.
// state_dbg exposes the FSM state for checkers.
module hp_tracker
    import game_pkg::*;
(
    input  logic        clk_22,
    input  logic        rst_n,
    input  logic        gamestart,
    input  logic [1:0]  scene,
    input  logic        boss_hit,
    input  logic [3:0]  boss_dmg,
    input  logic        player_hit,
    output logic [9:0]  bosshp,
    output logic [1:0]  life,
    output logic        invincible,
    output logic        hit_flash,
    output logic [1:0]  state_dbg
);

    logic [1:0]       state;
    logic [HP_W-1:0]  dmg_ext;
    logic [HP_W-1:0]  hp_sub;
    logic [HP_W-1:0]  hp_next;
    logic             boss_dead;
    logic             in_game;
    logic             tmr_go;
    logic             tmr_clear;
    logic             tmr_expire;
    logic [INV_W-1:0] tmr_count;

    // Saturating boss damage and the timer control strobes
    always_comb begin
        dmg_ext   = {{(HP_W-4){1'b0}}, boss_dmg};
        hp_sub    = (bosshp > dmg_ext) ? (bosshp - dmg_ext) : '0;
        hp_next   = boss_hit ? hp_sub : bosshp;
        boss_dead = (hp_next == '0);
        in_game   = (scene == SC_GAME);
        // Start invulnerability only when the hit leaves the game running
        tmr_go    = (state == ST_PLAY) && in_game && player_hit &&
                    (life > LIFE_W'(1)) && !boss_dead;
        tmr_clear = gamestart ||
                    ((state == ST_INVULN) && (!in_game || boss_dead));
    end

    inv_timer #(.W(INV_W)) u_inv_timer (
        .clk_22 (clk_22),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .load   (tmr_go),
        .start  (tmr_go),
        .ticks  (INV_TICKS),
        .busy   (invincible),
        .expire (tmr_expire),
        .count  (tmr_count)
    );

    // Session FSM with counters; gamestart reload beats every hit input
    always_ff @(posedge clk_22) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bosshp    <= BOSS_HP_INIT;
            life      <= LIFE_INIT;
            hit_flash <= 1'b0;
        end else if (gamestart) begin
            state     <= ST_IDLE;
            bosshp    <= BOSS_HP_INIT;
            life      <= LIFE_INIT;
            hit_flash <= 1'b0;
        end else begin
            hit_flash <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_game) begin
                        state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!in_game) begin
                        state <= ST_DONE;
                    end else begin
                        bosshp <= hp_next;
                        if (player_hit && life != '0) begin
                            life      <= life - LIFE_W'(1);
                            hit_flash <= 1'b1;
                        end
                        // A boss kill in the same cycle still counts as a win
                        if (boss_dead || (player_hit && life <= LIFE_W'(1))) begin
                            state <= ST_DONE;
                        end else if (player_hit) begin
                            state <= ST_INVULN;
                        end
                    end
                end
                ST_INVULN: begin
                    if (!in_game) begin
                        state <= ST_DONE;
                    end else begin
                        bosshp <= hp_next;
                        if (boss_dead) begin
                            state <= ST_DONE;
                        end else if (tmr_expire) begin
                            state <= ST_PLAY;
                        end
                    end
                end
                default: begin
                    state <= ST_DONE;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // The counter value is internal to the timer; only busy/expire matter here
    logic unused_ok;
    assign unused_ok = ^tmr_count;

endmodule

// File: tb/tb_hp_tracker.sv
// Directed bench for hp_tracker: reset, session start, boss saturation,
// invulnerability window, simultaneous hits, gamestart and reset recovery.
module tb_hp_tracker;
    import game_pkg::*;

    logic       clk_22;
    logic       rst_n;
    logic       gamestart;
    logic [1:0] scene;
    logic       boss_hit;
    logic [3:0] boss_dmg;
    logic       player_hit;
    logic [9:0] bosshp;
    logic [1:0] life;
    logic       invincible;
    logic       hit_flash;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    hp_tracker dut (
        .clk_22     (clk_22),
        .rst_n      (rst_n),
        .gamestart  (gamestart),
        .scene      (scene),
        .boss_hit   (boss_hit),
        .boss_dmg   (boss_dmg),
        .player_hit (player_hit),
        .bosshp     (bosshp),
        .life       (life),
        .invincible (invincible),
        .hit_flash  (hit_flash),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial clk_22 = 1'b0;
    always #5 clk_22 = ~clk_22;

    // Advance one edge and settle past it
    task automatic tick();
        @(posedge clk_22);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic boss(input logic [3:0] dmg);
        boss_hit = 1'b1;
        boss_dmg = dmg;
        tick();
        boss_hit = 1'b0;
        boss_dmg = 4'd0;
    endtask

    task automatic phit();
        player_hit = 1'b1;
        tick();
        player_hit = 1'b0;
    endtask

    task automatic wait_inv_drop();
        int n;
        n = 0;
        while (invincible && n < 100) begin
            tick();
            n++;
        end
        check("inv_timeout", 16'(invincible), 16'd0);
    endtask

    task automatic start_session();
        gamestart = 1'b1;
        tick();
        gamestart = 1'b0;
        scene     = SC_GAME;
        tick();
    endtask

    initial begin
        int inv_cnt;
        int flash_cnt;
        rst_n      = 1'b0;
        gamestart  = 1'b0;
        scene      = SC_OPEN;
        boss_hit   = 1'b0;
        boss_dmg   = 4'd0;
        player_hit = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_bosshp", 16'(bosshp), 16'd500);
        check("rst_life", 16'(life), 16'd3);
        check("rst_inv", 16'(invincible), 16'd0);
        check("rst_flash", 16'(hit_flash), 16'd0);
        check("rst_state", 16'(state_dbg), 16'(ST_IDLE));

        // Start a session: gamestart then scene=game
        rst_n = 1'b1;
        start_session();
        check("start_bosshp", 16'(bosshp), 16'd500);
        check("start_life", 16'(life), 16'd3);
        check("start_state", 16'(state_dbg), 16'(ST_PLAY));

        // Player hit: one-cycle latency to life/flash/invincible
        phit();
        check("hit_life", 16'(life), 16'd2);
        check("hit_flash", 16'(hit_flash), 16'd1);
        check("hit_inv", 16'(invincible), 16'd1);
        check("hit_state", 16'(state_dbg), 16'(ST_INVULN));

        // Invulnerability window: second hit ignored, boss hit applied
        inv_cnt   = 0;
        flash_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (invincible) inv_cnt++;
            if (hit_flash) flash_cnt++;
            player_hit = (i == 10);
            boss_hit   = (i == 15);
            boss_dmg   = (i == 15) ? 4'd4 : 4'd0;
            tick();
            player_hit = 1'b0;
            boss_hit   = 1'b0;
            boss_dmg   = 4'd0;
        end
        check("inv_cycles", 16'(inv_cnt), 16'd48);
        check("flash_cycles", 16'(flash_cnt), 16'd1);
        check("inv_life", 16'(life), 16'd2);
        check("inv_bosshp", 16'(bosshp), 16'd496);
        check("inv_exit_state", 16'(state_dbg), 16'(ST_PLAY));

        // Drain boss to 5, zero damage, then overkill saturates at 0
        for (int i = 0; i < 32; i++) boss(4'd15);
        boss(4'd11);
        check("drain_bosshp", 16'(bosshp), 16'd5);
        boss(4'd0);
        check("dmg0_bosshp", 16'(bosshp), 16'd5);
        boss(4'd9);
        check("sat_bosshp", 16'(bosshp), 16'd0);
        check("sat_state", 16'(state_dbg), 16'(ST_DONE));
        boss_hit   = 1'b1;
        boss_dmg   = 4'd5;
        player_hit = 1'b1;
        tick();
        boss_hit   = 1'b0;
        player_hit = 1'b0;
        tick();
        check("done_bosshp", 16'(bosshp), 16'd0);
        check("done_life", 16'(life), 16'd2);
        check("done_flash", 16'(hit_flash), 16'd0);

        // New session: life=1, bosshp=200, then simultaneous hits
        start_session();
        check("s2_state", 16'(state_dbg), 16'(ST_PLAY));
        phit();
        wait_inv_drop();
        phit();
        wait_inv_drop();
        for (int i = 0; i < 20; i++) boss(4'd15);
        check("s2_life", 16'(life), 16'd1);
        check("s2_bosshp", 16'(bosshp), 16'd200);
        check("s2_state_play", 16'(state_dbg), 16'(ST_PLAY));
        boss_hit   = 1'b1;
        boss_dmg   = 4'd3;
        player_hit = 1'b1;
        tick();
        boss_hit   = 1'b0;
        boss_dmg   = 4'd0;
        player_hit = 1'b0;
        check("both_life", 16'(life), 16'd0);
        check("both_bosshp", 16'(bosshp), 16'd197);
        check("both_state", 16'(state_dbg), 16'(ST_DONE));
        check("both_inv", 16'(invincible), 16'd0);
        check("both_flash", 16'(hit_flash), 16'd1);
        phit();
        check("both_life_hold", 16'(life), 16'd0);

        // gamestart while invulnerable with life=1
        start_session();
        phit();
        wait_inv_drop();
        phit();
        check("s3_inv_state", 16'(state_dbg), 16'(ST_INVULN));
        check("s3_inv_life", 16'(life), 16'd1);
        tick();
        tick();
        gamestart = 1'b1;
        tick();
        check("gs_life", 16'(life), 16'd3);
        check("gs_bosshp", 16'(bosshp), 16'd500);
        check("gs_inv", 16'(invincible), 16'd0);
        check("gs_state", 16'(state_dbg), 16'(ST_IDLE));
        gamestart = 1'b0;
        tick();
        check("gs_play", 16'(state_dbg), 16'(ST_PLAY));

        // Reset mid-PLAY with bosshp=123
        for (int i = 0; i < 25; i++) boss(4'd15);
        boss(4'd2);
        check("pre_rst_bosshp", 16'(bosshp), 16'd123);
        phit();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_bosshp", 16'(bosshp), 16'd500);
        check("rst2_life", 16'(life), 16'd3);
        check("rst2_flash", 16'(hit_flash), 16'd0);
        check("rst2_inv", 16'(invincible), 16'd0);
        check("rst2_state", 16'(state_dbg), 16'(ST_IDLE));

        // Scene leaves game while in PLAY: freeze in DONE
        tick();
        check("sc_play", 16'(state_dbg), 16'(ST_PLAY));
        scene = SC_WIN;
        boss(4'd7);
        check("sc_done", 16'(state_dbg), 16'(ST_DONE));
        check("sc_bosshp", 16'(bosshp), 16'd500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hp_tracker.md
# hp_tracker

Holds the boss hit-point counter and the player life counter for one play session, producing `bosshp` and `life` for the scene FSM's win/lose decision. Sits directly upstream of the scene FSM: it consumes hit pulses from collision logic plus `scene`/`gamestart` from the scene FSM, and returns the counts that end the game. Applies post-hit player invulnerability so one collision costs exactly one life.

## Interface
- `BOSS_HP_INIT`, 10'd500: boss HP loaded at session start.
- `LIFE_INIT`, 2'd3: player lives loaded at session start.
- `INV_TICKS`, 6'd48: invulnerability length in `clk_22` cycles, about 2 s; legal range 1–63.
- `clk_22`  in  1  game tick clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `gamestart`  in  1  from the scene FSM; high means load initial values.
- `scene`  in  2  current scene: 00 open, 01 game, 10 win, 11 lose.
- `boss_hit`  in  1  one-cycle pulse: player bullet struck boss.
- `boss_dmg`  in  4  damage for `boss_hit`; 0 is legal and means no change.
- `player_hit`  in  1  one-cycle pulse: enemy bullet or body struck player.
- `bosshp`  out  10  registered boss HP.
- `life`  out  2  registered player lives.
- `invincible`  out  1  high while a player hit is ignored.
- `hit_flash`  out  1  high for exactly 1 cycle after a hit that takes a life; drives the sprite blink.

## Operation
- States: `IDLE`, `PLAY`, `INVULN`, `DONE`.
- Reset (`rst_n`=0): state `IDLE`, `bosshp`=`BOSS_HP_INIT`, `life`=`LIFE_INIT`, `invincible`=0, `hit_flash`=0, invulnerability counter 0.
- Any state with `gamestart`=1: reload `bosshp`/`life`, clear counter, `invincible`, and `hit_flash`, then go to `IDLE`. This has priority over all hit inputs.
- `IDLE` → `PLAY` when `scene`=01 and `gamestart`=0. Hits are ignored in `IDLE`.
- `PLAY`:
  - `boss_hit`: `bosshp` ← `bosshp` − `boss_dmg`, saturating at 0. The 4-bit operand is zero-extended to 10 bits.
  - `player_hit`: `life` ← `life` − 1 and `hit_flash`=1 next cycle.
    - If the new life is nonzero: load the counter with `INV_TICKS` and go to `INVULN`.
    - If the new life is 0: go to `DONE`.
- `INVULN`: `invincible`=1. `player_hit` is ignored; `boss_hit` is still applied. The counter decrements each cycle; when it reads 1, go to `PLAY` and drop `invincible` in the same edge.
- `DONE` is entered when `bosshp` or `life` reaches 0. Both outputs freeze; all hits are ignored until `gamestart`.
- Simultaneous `boss_hit` and `player_hit` in `PLAY`: both apply in the same cycle.
  - If the boss reaches 0 in that cycle, go to `DONE` with `life` still decremented.
  - The scene FSM gives the win check priority, so this case counts as a win.
- If `scene` ≠ 01 while in `PLAY` or `INVULN`, go to `DONE` and freeze.
- `life` never underflows; `bosshp` never wraps.

## Timing
- All outputs are registered. A hit pulse at edge N is reflected in the outputs after edge N+1, giving 1-cycle latency.
- The scene FSM samples `bosshp`/`life` one cycle later, so total hit-to-scene latency is 2 cycles.
- `invincible` is high for exactly `INV_TICKS` cycles, starting with the cycle where `life` shows the decrement.
- `gamestart` reload completes in 1 cycle.
- Reset mid-`INVULN` clears `invincible` on the next edge.

## Structure
- Shared package `game_pkg`:
  - scene encodings `SC_OPEN`, `SC_GAME`, `SC_WIN`, `SC_LOSE`;
  - widths `HP_W`=10 and `LIFE_W`=2.
- The scene FSM imports the same package.
- One sub-module, `inv_timer`:
  - loadable down-counter with `load` and `start` inputs and a `busy` output;
  - generates `invincible` and the exit condition.
- Saturating subtract stays inline.

## Test plan
- Reset, then `gamestart`=1, then `scene`=01 → `bosshp`=500, `life`=3, state `PLAY`.
- `boss_hit` with `boss_dmg`=9 while `bosshp`=5 → `bosshp`=0 next cycle, state `DONE`. Further `boss_hit` pulses leave it at 0.
- `player_hit` at cycle N → `life`=2 and `hit_flash`=1 at N+1. `invincible` is high for 48 cycles.
  - A second `player_hit` 10 cycles later is ignored, `life`=2.
  - `boss_hit` with `boss_dmg`=4 during invulnerability → `bosshp`=496.
- With `life`=1, apply `player_hit` together with `boss_hit`/`boss_dmg`=3 at `bosshp`=200 → `life`=0, `bosshp`=197, state `DONE`, `invincible` stays 0.
- Assert `gamestart` in `INVULN` with `life`=1 → next cycle `life`=3, `bosshp`=500, `invincible`=0, state `IDLE`.
- Drive `rst_n`=0 for 1 cycle in `PLAY` with `bosshp`=123 → `bosshp`=500, `life`=3, `hit_flash`=0.
